// File: rtl/alarm_ctrl_fsm.sv
// alarm_ctrl_fsm
// Central alarm sequencer: DISARMED -> EXIT_DELAY -> ARMED -> ENTRY_DELAY
// -> ALARM, with second-resolution countdowns driven by a 1 Hz tick.
//
// Handshake/timing: every input is a level or one-cycle pulse sampled on
// the rising edge of i_clk. All outputs are registered, so an input sampled
// at edge N shows up on the outputs just after edge N. There is no
// back-pressure; pulses are consumed in the cycle they are seen.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_tick       one-cycle pulse, once per second
//   i_arm        one-cycle arm request
//   i_disarm     one-cycle disarm (code already validated upstream)
//   i_panic      one-cycle panic request
//   i_door       door sensor level, 1 = open
//   o_state      current state code (0..4), doubles as FSM debug output
//   o_countdown  remaining seconds of the running timer, 0 otherwise
//   o_siren      siren drive, high in ALARM
//   o_armed_led  armed indicator (blinks per tick during exit delay)
//   o_alarm_evt  one-cycle pulse on every entry into ALARM
module alarm_ctrl_fsm #(
  parameter int EXIT_DELAY_S  = 10,
  parameter int ENTRY_DELAY_S = 15,
  parameter int ALARM_TIME_S  = 180,
  parameter int CNT_W         = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic             i_arm,
  input  logic             i_disarm,
  input  logic             i_panic,
  input  logic             i_door,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_countdown,
  output logic             o_siren,
  output logic             o_armed_led,
  output logic             o_alarm_evt
);

  localparam logic [2:0] S_DISARMED    = 3'd0;
  localparam logic [2:0] S_EXIT_DELAY  = 3'd1;
  localparam logic [2:0] S_ARMED       = 3'd2;
  localparam logic [2:0] S_ENTRY_DELAY = 3'd3;
  localparam logic [2:0] S_ALARM       = 3'd4;

  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY_S);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY_S);
  localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_TIME_S);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             evt_q, evt_d;
  logic             siren_q;

  // A tick on a count of 1 (or, defensively, 0) expires the timer, so the
  // countdown can never wrap below zero.
  logic expire;
  assign expire = i_tick && (cnt_q <= CNT_ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    evt_d   = 1'b0;
    if (state_q > S_ALARM) begin
      // Unreachable codes recover to DISARMED.
      state_d = S_DISARMED;
      cnt_d   = CNT_ZERO;
      led_d   = 1'b0;
    end else if (i_disarm) begin
      // Disarm dominates panic/arm; in DISARMED it simply holds the state.
      state_d = S_DISARMED;
      cnt_d   = CNT_ZERO;
      led_d   = 1'b0;
    end else if (i_panic) begin
      // Panic in ALARM only restarts the siren timer, no new event pulse.
      state_d = S_ALARM;
      cnt_d   = ALARM_LOAD;
      led_d   = 1'b1;
      evt_d   = (state_q != S_ALARM);
    end else begin
      case (state_q)
        S_DISARMED: begin
          cnt_d = CNT_ZERO;
          led_d = 1'b0;
          if (i_arm) begin
            state_d = S_EXIT_DELAY;
            cnt_d   = EXIT_LOAD;
            led_d   = 1'b1;
          end
        end
        S_EXIT_DELAY: begin
          if (expire) begin
            state_d = S_ARMED;
            cnt_d   = CNT_ZERO;
            led_d   = 1'b1;
          end else if (i_tick) begin
            cnt_d = cnt_q - CNT_ONE;
            led_d = ~led_q;
          end
        end
        S_ARMED: begin
          cnt_d = CNT_ZERO;
          led_d = 1'b1;
          if (i_door) begin
            state_d = S_ENTRY_DELAY;
            cnt_d   = ENTRY_LOAD;
          end
        end
        S_ENTRY_DELAY: begin
          led_d = 1'b1;
          if (expire) begin
            state_d = S_ALARM;
            cnt_d   = ALARM_LOAD;
            evt_d   = 1'b1;
          end else if (i_tick) begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_ALARM: begin
          led_d = 1'b1;
          // Expiry returns to ARMED; an open door re-triggers entry delay
          // on the following cycle through the ARMED branch.
          if (expire) begin
            state_d = S_ARMED;
            cnt_d   = CNT_ZERO;
          end else if (i_tick) begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = S_DISARMED;
          cnt_d   = CNT_ZERO;
          led_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_DISARMED;
      cnt_q   <= CNT_ZERO;
      led_q   <= 1'b0;
      evt_q   <= 1'b0;
      siren_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      evt_q   <= evt_d;
      siren_q <= (state_d == S_ALARM);
    end
  end

  assign o_state     = state_q;
  assign o_countdown = cnt_q;
  assign o_siren     = siren_q;
  assign o_armed_led = led_q;
  assign o_alarm_evt = evt_q;

endmodule

// File: tb/tb_alarm_ctrl_fsm.sv
// Testbench for alarm_ctrl_fsm: vector table, directed multi-cycle
// sequences and randomized stimulus against a behavioural model.
module tb_alarm_ctrl_fsm;

  localparam int EXIT_S  = 10;
  localparam int ENTRY_S = 15;
  localparam int ALARM_S = 180;
  localparam int CW      = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0, tick = 1'b0, arm = 1'b0, disarm = 1'b0;
  logic          panic = 1'b0, door = 1'b0;
  logic [2:0]    st;
  logic [CW-1:0] cnt;
  logic          siren, led, evt;

  always #5 clk = ~clk;

  alarm_ctrl_fsm #(
    .EXIT_DELAY_S(EXIT_S), .ENTRY_DELAY_S(ENTRY_S),
    .ALARM_TIME_S(ALARM_S), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_arm(arm),
    .i_disarm(disarm), .i_panic(panic), .i_door(door),
    .o_state(st), .o_countdown(cnt), .o_siren(siren),
    .o_armed_led(led), .o_alarm_evt(evt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_LEAVING, M_WATCHING, M_ENTERING, M_RINGING} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_secs = 0;    // seconds left on the running timer
  bit    m_blink = 0;   // LED phase while leaving
  bit    m_evt = 0;

  function automatic int code_of(mode_t m);
    case (m)
      M_IDLE:     return 0;
      M_LEAVING:  return 1;
      M_WATCHING: return 2;
      M_ENTERING: return 3;
      default:    return 4;
    endcase
  endfunction

  function automatic void start_ringing();
    if (m_mode != M_RINGING) m_evt = 1;
    m_mode = M_RINGING;
    m_secs = ALARM_S;
  endfunction

  function automatic void model_step(bit r, bit t, bit a, bit d, bit p, bit dr);
    m_evt = 0;
    if (r) begin
      m_mode = M_IDLE; m_secs = 0; m_blink = 0;
    end else if (d) begin
      m_mode = M_IDLE; m_secs = 0;
    end else if (p) begin
      start_ringing();
    end else if (a && m_mode == M_IDLE) begin
      m_mode = M_LEAVING; m_secs = EXIT_S; m_blink = 1;
    end else if (m_mode == M_WATCHING) begin
      if (dr) begin m_mode = M_ENTERING; m_secs = ENTRY_S; end
    end else if (t && m_mode != M_IDLE) begin
      m_secs = m_secs - 1;
      m_blink = !m_blink;
      if (m_secs <= 0) begin
        m_secs = 0;
        case (m_mode)
          M_LEAVING:  m_mode = M_WATCHING;
          M_ENTERING: start_ringing();
          default:    m_mode = M_WATCHING;
        endcase
      end
    end
  endfunction

  function automatic int model_led();
    if (m_mode == M_LEAVING) return int'(m_blink);
    return (m_mode == M_WATCHING || m_mode == M_ENTERING || m_mode == M_RINGING) ? 1 : 0;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic exp_out(input string tag, input int e_st, input int e_cnt,
                         input int e_siren, input int e_led, input int e_evt);
    chk({tag, ".state"}, int'(st), e_st);
    chk({tag, ".countdown"}, int'(cnt), e_cnt);
    chk({tag, ".siren"}, int'(siren), e_siren);
    chk({tag, ".led"}, int'(led), e_led);
    chk({tag, ".evt"}, int'(evt), e_evt);
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, sample 1 ns after the rising edge, advance
  // the model and compare every output against it.
  task automatic step(input bit r, input bit t, input bit a, input bit d,
                      input bit p, input bit dr);
    @(negedge clk);
    rst = r; tick = t; arm = a; disarm = d; panic = p; door = dr;
    @(posedge clk);
    #1;
    model_step(r, t, a, d, p, dr);
    exp_out("model", code_of(m_mode), m_secs, (m_mode == M_RINGING) ? 1 : 0,
            model_led(), int'(m_evt));
  endtask

  task automatic ticks(input int n, input bit dr);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, dr);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit r, t, a, d, p, dr;
    int e_st, e_cnt, e_siren, e_led, e_evt;
  } vec_t;

  function automatic vec_t mk(bit r, bit t, bit a, bit d, bit p, bit dr,
                              int e_st, int e_cnt, int e_siren, int e_led, int e_evt);
    vec_t v;
    v.r = r; v.t = t; v.a = a; v.d = d; v.p = p; v.dr = dr;
    v.e_st = e_st; v.e_cnt = e_cnt; v.e_siren = e_siren; v.e_led = e_led; v.e_evt = e_evt;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    //           r t a d p dr   st cnt sir led evt
    vecs[0]  = mk(1,0,0,0,0,0,  0,  0, 0,  0,  0);   // reset
    vecs[1]  = mk(0,0,1,0,0,0,  1, 10, 0,  1,  0);   // arm
    vecs[2]  = mk(0,1,0,0,0,0,  1,  9, 0,  0,  0);   // tick, led toggles
    vecs[3]  = mk(0,1,0,0,0,0,  1,  8, 0,  1,  0);
    vecs[4]  = mk(0,0,0,0,0,1,  1,  8, 0,  1,  0);   // door ignored
    vecs[5]  = mk(0,0,1,0,0,0,  1,  8, 0,  1,  0);   // arm ignored
    vecs[6]  = mk(0,0,0,0,1,0,  4,180, 1,  1,  1);   // panic
    vecs[7]  = mk(0,0,0,0,0,0,  4,180, 1,  1,  0);   // evt one cycle
    vecs[8]  = mk(0,1,0,0,0,0,  4,179, 1,  1,  0);
    vecs[9]  = mk(0,0,0,0,1,0,  4,180, 1,  1,  0);   // panic reload, no evt
    vecs[10] = mk(0,0,0,1,1,0,  0,  0, 0,  0,  0);   // disarm beats panic
    vecs[11] = mk(0,0,0,0,0,1,  0,  0, 0,  0,  0);   // door ignored
    vecs[12] = mk(0,0,1,0,1,0,  4,180, 1,  1,  1);   // panic beats arm
    vecs[13] = mk(1,0,0,0,1,0,  0,  0, 0,  0,  0);   // reset beats panic
    vecs[14] = mk(0,1,1,0,0,0,  1, 10, 0,  1,  0);   // tick on entry ignored
    vecs[15] = mk(0,0,0,1,0,1,  0,  0, 0,  0,  0);   // disarm in exit delay

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].r, vecs[i].t, vecs[i].a, vecs[i].d, vecs[i].p, vecs[i].dr);
      exp_out($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_cnt,
              vecs[i].e_siren, vecs[i].e_led, vecs[i].e_evt);
    end

    // ---- arm, full exit delay ----
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("exit.load", int'(cnt), EXIT_S);
    for (int k = 1; k <= EXIT_S; k++) begin
      step(0, 1, 0, 0, 0, 0);
      if (k < EXIT_S) begin
        chk("exit.state", int'(st), 1);
        chk("exit.cnt", int'(cnt), EXIT_S - k);
        chk("exit.led", int'(led), (k % 2 == 1) ? 0 : 1);
      end else begin
        exp_out("exit.done", 2, 0, 0, 1, 0);
      end
    end

    // ---- door opens, entry delay to alarm ----
    step(0, 0, 0, 0, 0, 1);
    exp_out("entry.start", 3, ENTRY_S, 0, 1, 0);
    for (int k = 1; k <= ENTRY_S; k++) begin
      step(0, 1, 0, 0, 0, 0);
      if (k < ENTRY_S) chk("entry.cnt", int'(cnt), ENTRY_S - k);
      else exp_out("entry.alarm", 4, ALARM_S, 1, 1, 1);
    end
    step(0, 0, 0, 0, 0, 0);
    exp_out("entry.evt_once", 4, ALARM_S, 1, 1, 0);

    // ---- disarm coincident with tick at countdown 3 ----
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    ticks(EXIT_S, 0);
    step(0, 0, 0, 0, 0, 1);
    ticks(ENTRY_S - 3, 0);
    chk("dis.cnt3", int'(cnt), 3);
    step(0, 1, 0, 1, 0, 0);
    exp_out("dis.result", 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    exp_out("dis.hold", 0, 0, 0, 0, 0);

    // ---- panic+arm, second panic at 50, then door-open expiry ----
    step(0, 0, 1, 0, 1, 0);
    exp_out("pan.enter", 4, ALARM_S, 1, 1, 1);
    ticks(ALARM_S - 50, 0);
    chk("pan.cnt50", int'(cnt), 50);
    step(0, 0, 0, 0, 1, 0);
    exp_out("pan.reload", 4, ALARM_S, 1, 1, 0);
    for (int k = 1; k <= ALARM_S; k++) begin
      step(0, 1, 0, 0, 0, 1);
      if (k == ALARM_S) exp_out("ring.expire", 2, 0, 0, 1, 0);
    end
    step(0, 0, 0, 0, 0, 1);
    exp_out("ring.retrigger", 3, ENTRY_S, 0, 1, 0);

    // ---- reset mid-alarm at countdown 77 ----
    step(0, 0, 0, 0, 1, 0);
    ticks(ALARM_S - 77, 0);
    chk("rst.cnt77", int'(cnt), 77);
    step(1, 1, 0, 0, 0, 1);
    exp_out("rst.mid_alarm", 0, 0, 0, 0, 0);

    // ---- randomized stimulus vs model ----
    begin
      bit r, t, a, d, p, dr;
      dr = 0;
      for (int i = 0; i < 6000; i++) begin
        r = ($urandom_range(0, 999) < 3);
        t = ($urandom_range(0, 99) < 35);
        a = ($urandom_range(0, 99) < 6);
        d = ($urandom_range(0, 99) < 2);
        p = ($urandom_range(0, 199) < 3);
        if ($urandom_range(0, 99) < 8) dr = !dr;
        // Keep disarm and panic apart while idle so only unambiguous cases occur.
        if (m_mode == M_IDLE && d) p = 0;
        step(r, t, a, d, p, dr);
      end
    end

    @(negedge clk);
    rst = 0; tick = 0; arm = 0; disarm = 0; panic = 0; door = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
